// File: rtl/e1b_code_loader.sv
// ---------------------------------------------------------------------------
// e1b_code_loader
//
// Fills the E1B code memory from a host valid/ready word stream. Each load
// pulses the memory write-address reset, accepts exactly CODELEN words and
// forwards each one as a registered write one clock after its handshake.
// code_valid is only raised once a complete, error-free image is resident,
// so the GPS channels never run from a partial code.
//
// Optional feature: define E1B_LOADER_CSUM_EN to add a mod-2^16 checksum
// of the accepted words. A mismatch against csum_exp on completion sends
// the loader to ERR instead of reporting done.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   start, abort  single-cycle load request / cancel request
//   s_valid       host word valid
//   s_data        host code word
//   s_ready       loader accepts a word this cycle
//   mem_rst       one-cycle reset of the memory write-address counter
//   wr, tos       code memory write strobe and write data
//   busy          load in progress (CLEAR or LOAD)
//   done          sticky, last load completed OK
//   err_timeout   sticky, stream stalled for TIMEOUT_CYC cycles
//   err_busy      sticky, start seen while busy
//   code_valid    memory holds a complete image
//   word_cnt      words accepted in the current/last load
//   csum_exp      (CSUM_EN) expected checksum
//   csum          (CSUM_EN) running checksum of accepted words
//   err_csum      (CSUM_EN) sticky, checksum mismatch on completion
// ---------------------------------------------------------------------------
module e1b_code_loader #(
    parameter int CODELEN     = 4092,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
`ifdef E1B_LOADER_CSUM_EN
    input  logic [15:0]       csum_exp,
    output logic [15:0]       csum,
    output logic              err_csum,
`endif
    output logic              s_ready,
    output logic              mem_rst,
    output logic              wr,
    output logic [DATA_W-1:0] tos,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_busy,
    output logic              code_valid,
    output logic [11:0]       word_cnt
);

    localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [11:0]    CNT_FULL  = 12'(CODELEN);
    localparam logic [11:0]    CNT_LAST  = 12'(CODELEN - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  TO_ONE    = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   idle_cnt_r;
    logic            accept_s;

`ifdef E1B_LOADER_CSUM_EN
    // Mod-2^16 accumulate of one zero-extended code word.
    function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                             input logic [DATA_W-1:0] w);
        return acc + 16'(w);
    endfunction
`endif

    // A word is taken only in LOAD; an abort in the same cycle cancels it.
    assign accept_s = (state_r == ST_LOAD) && s_ready && s_valid && !abort;

    // Load sequencer: state, counters, status flags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idle_cnt_r  <= '0;
            s_ready     <= 1'b0;
            mem_rst     <= 1'b0;
            wr          <= 1'b0;
            tos         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_busy    <= 1'b0;
            code_valid  <= 1'b0;
            word_cnt    <= 12'd0;
`ifdef E1B_LOADER_CSUM_EN
            csum        <= 16'd0;
            err_csum    <= 1'b0;
`endif
        end else begin
            // Strobes default low; tos holds its last value.
            wr      <= 1'b0;
            mem_rst <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ERR: begin
                    // start beats a simultaneous abort here.
                    if (start) begin
                        state_r     <= ST_CLEAR;
                        mem_rst     <= 1'b1;
                        busy        <= 1'b1;
                        s_ready     <= 1'b0;
                        done        <= 1'b0;
                        err_timeout <= 1'b0;
                        err_busy    <= 1'b0;
                        code_valid  <= 1'b0;
                        word_cnt    <= 12'd0;
                        idle_cnt_r  <= '0;
`ifdef E1B_LOADER_CSUM_EN
                        csum        <= 16'd0;
                        err_csum    <= 1'b0;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        s_ready <= 1'b0;
                    end else begin
                        if (start) begin
                            err_busy <= 1'b1;
                        end else begin
                            err_busy <= err_busy;
                        end
                        state_r <= ST_LOAD;
                        s_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        s_ready <= 1'b0;
                    end else begin
                        if (start) begin
                            err_busy <= 1'b1;
                        end else begin
                            err_busy <= err_busy;
                        end
                        if (word_cnt == CNT_FULL) begin
                            // Final write went out last cycle; report now.
                            busy    <= 1'b0;
                            s_ready <= 1'b0;
`ifdef E1B_LOADER_CSUM_EN
                            if (csum != csum_exp) begin
                                state_r  <= ST_ERR;
                                err_csum <= 1'b1;
                            end else begin
                                state_r    <= ST_IDLE;
                                done       <= 1'b1;
                                code_valid <= 1'b1;
                            end
`else
                            state_r    <= ST_IDLE;
                            done       <= 1'b1;
                            code_valid <= 1'b1;
`endif
                        end else if (accept_s) begin
                            wr         <= 1'b1;
                            tos        <= s_data;
                            word_cnt   <= word_cnt + 12'd1;
                            idle_cnt_r <= '0;
                            // Drop ready right after the last word is taken.
                            s_ready    <= (word_cnt != CNT_LAST);
`ifdef E1B_LOADER_CSUM_EN
                            csum       <= csum_add(csum, s_data);
`endif
                        end else if (idle_cnt_r == TO_LAST) begin
                            state_r     <= ST_ERR;
                            err_timeout <= 1'b1;
                            busy        <= 1'b0;
                            s_ready     <= 1'b0;
                            idle_cnt_r  <= idle_cnt_r + TO_ONE;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + TO_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e1b_code_loader.sv
// ---------------------------------------------------------------------------
// tb_e1b_code_loader
//
// Self-checking bench for e1b_code_loader. Full-load scenarios come from a
// table; stall/timeout, abort, start+abort and checksum cases are written
// out by hand. Every accepted word is pushed to a scoreboard with the cycle
// its write must appear in; a monitor pops and compares on each wr.
// The timeout is shortened so the stall case stays brief.
// ---------------------------------------------------------------------------
module tb_e1b_code_loader;

    localparam int CODELEN = 4092;
    localparam int DW      = 12;
    localparam int TO      = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          mem_rst;
    logic          wr;
    logic [DW-1:0] tos;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_busy;
    logic          code_valid;
    logic [11:0]   word_cnt;
`ifdef E1B_LOADER_CSUM_EN
    logic [15:0]   csum_exp;
    logic [15:0]   csum;
    logic          err_csum;
`endif

    e1b_code_loader #(
        .CODELEN    (CODELEN),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
`ifdef E1B_LOADER_CSUM_EN
        .csum_exp   (csum_exp),
        .csum       (csum),
        .err_csum   (err_csum),
`endif
        .s_ready    (s_ready),
        .mem_rst    (mem_rst),
        .wr         (wr),
        .tos        (tos),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .err_busy   (err_busy),
        .code_valid (code_valid),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    typedef struct {
        int n;
        int duty;
        int start_at;
        int exp_cnt;
        bit exp_done;
        bit exp_cv;
        bit exp_ebusy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[3];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   cyc         = 0;
    int   wr_cnt      = 0;
    int   mem_rst_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: each wr must match the oldest accepted word, one clock late.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_rst) mem_rst_cnt++;
            if (wr) begin
                wr_cnt++;
                check("wr_has_expect", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("tos", 32'(tos), 32'(e.data));
                    check("wr_latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            start   = 1'b0;
            abort   = 1'b0;
            s_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("clear_mem_rst", 32'(mem_rst), 32'd1);
        check("clear_busy", 32'(busy), 32'd1);
        check("clear_done", 32'(done), 32'd0);
        check("clear_cv", 32'(code_valid), 32'd0);
        check("clear_err_to", 32'(err_timeout), 32'd0);
    endtask

    // Offer words at duty% until n are accepted; optionally pulse start.
    task automatic stream(input int n, input int duty, input int start_at,
                          input int fixed);
        int            acc   = 0;
        int            guard = 0;
        bit            sdone = 1'b0;
        logic [DW-1:0] w;
        w = (fixed >= 0) ? DW'(fixed) : DW'($urandom);
        while (acc < n && guard < 40000) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            abort = 1'b0;
            if (!sdone && acc == start_at) begin
                start = 1'b1;
                sdone = 1'b1;
            end
            s_valid = (int'($urandom_range(99)) < duty);
            s_data  = w;
            if (s_valid && s_ready) begin
                sb.push_back('{w, cyc + 1});
                acc++;
                w = (fixed >= 0) ? DW'(fixed) : DW'($urandom);
            end
        end
        check("stream_accepted", acc, n);
    endtask

    initial begin : watchdog
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : main
        int wr0;
        int mr0;

        vecs[0] = '{CODELEN, 100, -1, CODELEN, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{CODELEN, 30,  -1, CODELEN, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{CODELEN, 100, 1500, CODELEN, 1'b1, 1'b1, 1'b1};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
`ifdef E1B_LOADER_CSUM_EN
        csum_exp = 16'd0;
`endif
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_mem_rst", 32'(mem_rst), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_tos", 32'(tos), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_to", 32'(err_timeout), 32'd0);
        check("rst_err_busy", 32'(err_busy), 32'd0);
        check("rst_cv", 32'(code_valid), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven full loads, each followed by an excess word offer.
        for (int v = 0; v < 3; v++) begin
            wr0 = wr_cnt;
            mr0 = mem_rst_cnt;
            do_start();
            stream(vecs[v].n, vecs[v].duty, vecs[v].start_at, -1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                start   = 1'b0;
                abort   = 1'b0;
                s_valid = 1'b1;
                s_data  = 12'hABC;
                check("excess_ready", 32'(s_ready), 32'd0);
                if (i == 0) begin
                    check("last_wr", 32'(wr), 32'd1);
                    check("busy_last_wr", 32'(busy), 32'd1);
                    check("done_early", 32'(done), 32'd0);
                end
                if (i == 1) begin
                    check("busy_end", 32'(busy), 32'd0);
                    check("done", 32'(done), 32'(vecs[v].exp_done));
                    check("code_valid", 32'(code_valid), 32'(vecs[v].exp_cv));
                end
            end
            idle_cycles(2);
            check("word_cnt", 32'(word_cnt), vecs[v].exp_cnt);
            check("err_busy", 32'(err_busy), 32'(vecs[v].exp_ebusy));
            check("no_timeout", 32'(err_timeout), 32'd0);
            check("wr_count", wr_cnt - wr0, vecs[v].exp_cnt);
            check("mem_rst_pulses", mem_rst_cnt - mr0, 32'd1);
            check("sb_empty", sb.size(), 32'd0);
        end

        // Stall: 100 words, then idle right up to and past the timeout.
        do_start();
        stream(100, 100, -1, -1);
        idle_cycles(TO);
        check("stall_no_err_yet", 32'(err_timeout), 32'd0);
        check("stall_busy_yet", 32'(busy), 32'd1);
        idle_cycles(1);
        check("stall_err_to", 32'(err_timeout), 32'd1);
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_cv", 32'(code_valid), 32'd0);
        check("stall_word_cnt", 32'(word_cnt), 32'd100);
        check("stall_ready", 32'(s_ready), 32'd0);
        idle_cycles(5);
        check("err_sticky", 32'(err_timeout), 32'd1);
        check("err_stays", 32'(busy), 32'd0);

        // Recovery from ERR with a throttled stream.
        do_start();
        stream(CODELEN, 50, -1, -1);
        idle_cycles(3);
        check("recov_done", 32'(done), 32'd1);
        check("recov_cv", 32'(code_valid), 32'd1);
        check("recov_word_cnt", 32'(word_cnt), CODELEN);
        check("recov_sb_empty", sb.size(), 32'd0);

        // Abort at word 2000 with a word still being offered.
        wr0 = wr_cnt;
        do_start();
        stream(2000, 100, -1, -1);
        @(negedge clk);
        abort   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 12'h555;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            abort   = 1'b0;
            s_valid = 1'b1;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_ready", 32'(s_ready), 32'd0);
        end
        idle_cycles(2);
        check("abort_word_cnt", 32'(word_cnt), 32'd2000);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cv", 32'(code_valid), 32'd0);
        check("abort_wr_count", wr_cnt - wr0, 32'd2000);
        check("abort_sb_empty", sb.size(), 32'd0);

        // start and abort together mid-load: abort wins.
        do_start();
        stream(500, 100, -1, -1);
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_mem_rst", 32'(mem_rst), 32'd0);
        check("sa_ready", 32'(s_ready), 32'd0);
        idle_cycles(2);
        check("sa_word_cnt", 32'(word_cnt), 32'd500);
        check("sa_done", 32'(done), 32'd0);
        check("sa_sb_empty", sb.size(), 32'd0);

`ifdef E1B_LOADER_CSUM_EN
        // Checksum match and mismatch with all-ones-LSB words.
        csum_exp = 16'h0FFC;
        do_start();
        stream(CODELEN, 100, -1, 1);
        idle_cycles(3);
        check("csum_value", 32'(csum), 32'h0FFC);
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_cv", 32'(code_valid), 32'd1);
        check("csum_ok_err", 32'(err_csum), 32'd0);
        csum_exp = 16'h0FFB;
        do_start();
        stream(CODELEN, 100, -1, 1);
        idle_cycles(3);
        check("csum_bad_err", 32'(err_csum), 32'd1);
        check("csum_bad_cv", 32'(code_valid), 32'd0);
        check("csum_bad_done", 32'(done), 32'd0);
        check("csum_bad_busy", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
